// File: rtl/apb_arb_pkg.sv
// Shared FSM encoding and width helpers for the APB request arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package apb_arb_pkg;

   // Arbiter FSM: IDLE waits for a request, BUSY owns the master, GAP idles the bus one cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Width of a requester index / round-robin pointer
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the BUSY-cycle counter; at least one bit even with the timeout disabled
   function automatic int cnt_w(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Round-robin priority select: first set request at or after ptr, wrapping circularly.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx,
   output logic          any
);

   int j;

   // Scan N slots starting at ptr; the first hit wins and later slots are masked
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int k = 0; k < N; k++) begin
         if (!any) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
               any       = 1'b1;
               idx       = PW'(j);
               onehot[j] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// Latency: req sampled at edge k drives transfer in the next cycle; done/err one cycle after m_done/timeout.
// Backpressure: the owner holds the master until m_done or timeout; other requesters wait in req.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        err,
   output logic [DATA_W-1:0]         rdata,
   output logic                      transfer,
   output logic                      write_en,
   output logic [ADDR_W-1:0]         addr_in,
   output logic [DATA_W-1:0]         din,
   input  logic [DATA_W-1:0]         dout,
   input  logic                      m_done
);

   localparam int IW      = idx_w(NUM_REQ);
   localparam int CW      = cnt_w(TIMEOUT);
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   arb_state_t      state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [CW-1:0]   cnt;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               timeout_hit;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (IW)
   ) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // A timeout only fires on the last allowed BUSY cycle and loses to a simultaneous m_done
   assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && !m_done && (cnt == CW'(TO_LAST));

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state: GAP always lasts exactly one cycle so the master can fall back to idle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = BUSY;
         BUSY:    if (m_done || timeout_hit) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latching, master drive, completion pulses and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         grant    <= '0;
         done     <= '0;
         err      <= '0;
         rdata    <= '0;
         transfer <= 1'b0;
         write_en <= 1'b0;
         addr_in  <= '0;
         din      <= '0;
         owner    <= '0;
         rr_ptr   <= '0;
         cnt      <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant    <= pick_oh;
                  owner    <= pick_idx;
                  write_en <= req_write[pick_idx];
                  addr_in  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                  din      <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                  transfer <= 1'b1;
                  cnt      <= '0;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (m_done || timeout_hit) begin
                  if (m_done) begin
                     if (!write_en) rdata <= dout;
                     done <= grant;
                  end else begin
                     err <= grant;
                  end
                  transfer <= 1'b0;
                  grant    <= '0;
                  rr_ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a per-cycle reference model.
// Latency: model predicts registered outputs one edge after the sampled inputs.
// Backpressure: bench plays the master, pulsing m_done on a chosen cycle.
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req, req_write;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      grant, done, err;
   logic [DW-1:0]     rdata, din, dout;
   logic              transfer, write_en, m_done;
   logic [AW-1:0]     addr_in;

   apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
      .err(err), .rdata(rdata), .transfer(transfer), .write_en(write_en),
      .addr_in(addr_in), .din(din), .dout(dout), .m_done(m_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integers for phase/owner/age, updated at each rising edge
   int phase = 0;   // 0 waiting, 1 owning master, 2 bus gap
   int m_owner = 0, m_age = 0, m_ptr = 0;
   logic [N-1:0]  e_grant = '0, e_done = '0, e_err = '0;
   logic [DW-1:0] e_rdata = '0, e_din = '0;
   logic [AW-1:0] e_addr = '0;
   logic          e_tr = 1'b0, e_we = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         phase = 0; m_ptr = 0; m_age = 0;
         e_grant = '0; e_done = '0; e_err = '0; e_rdata = '0;
         e_din = '0; e_addr = '0; e_tr = 1'b0; e_we = 1'b0;
      end else begin
         e_done = '0;
         e_err  = '0;
         if (phase == 0) begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++)
               if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
               m_owner = w; m_age = 0; phase = 1;
               e_grant = '0; e_grant[w] = 1'b1;
               e_we = req_write[w];
               e_addr = req_addr[w*AW +: AW];
               e_din = req_wdata[w*DW +: DW];
               e_tr = 1'b1;
            end
         end else if (phase == 1) begin
            if (m_done || m_age == TO - 1) begin
               if (m_done) begin
                  if (!e_we) e_rdata = dout;
                  e_done[m_owner] = 1'b1;
               end else begin
                  e_err[m_owner] = 1'b1;
               end
               e_tr = 1'b0; e_grant = '0;
               m_ptr = (m_owner + 1) % N;
               phase = 2;
            end else begin
               m_age++;
            end
         end else begin
            phase = 0;
         end
      end
   end

   // Compare every DUT output against the model on each falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("grant", 32'(grant), 32'(e_grant));
         chk("done", 32'(done), 32'(e_done));
         chk("err", 32'(err), 32'(e_err));
         chk("rdata", 32'(rdata), 32'(e_rdata));
         chk("transfer", 32'(transfer), 32'(e_tr));
         chk("write_en", 32'(write_en), 32'(e_we));
         chk("addr_in", 32'(addr_in), 32'(e_addr));
         chk("din", 32'(din), 32'(e_din));
      end
   end

   int done1_cnt = 0;
   always @(negedge clk) if (done[1] === 1'b1) done1_cnt++;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_transfer();
      for (int i = 0; i < 8; i++) begin
         if (transfer === 1'b1) break;
         tick();
      end
      chk("transfer_seen", 32'(transfer), 32'd1);
   endtask

   task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[r] = 1'b1;
      req_write[r] = wr;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   int order[$];
   int busy_cycles;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      reset = 1'b1; m_done = 1'b0; dout = '0;
      req = '0; req_write = '0; req_addr = '0; req_wdata = '0;

      // 1. reset with random inputs
      @(posedge clk);
      tick();
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req = N'($urandom); req_write = N'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         dout = DW'($urandom); m_done = 1'($urandom);
         tick();
         chk("rst_grant", 32'(grant), 32'd0);
         chk("rst_transfer", 32'(transfer), 32'd0);
      end
      req = '0; req_write = '0; m_done = 1'b0; dout = '0;
      reset = 1'b0;
      tick(); tick();

      // 2. single write from requester 1
      done1_cnt = 0;
      set_req(1, 1'b1, 8'hA5, 8'h3C);
      tick();
      wait_transfer();
      chk("wr_grant", 32'(grant), 32'h2);
      chk("wr_addr", 32'(addr_in), 32'hA5);
      chk("wr_din", 32'(din), 32'h3C);
      chk("wr_we", 32'(write_en), 32'd1);
      tick(); tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("wr_done", 32'(done), 32'h2);
      req = '0;
      tick();
      chk("wr_gap_transfer", 32'(transfer), 32'd0);
      tick();
      chk("wr_done_once", 32'(done1_cnt), 32'd1);

      // 3. read from requester 2
      set_req(2, 1'b0, 8'hA5, 8'h00);
      tick();
      wait_transfer();
      chk("rd_grant", 32'(grant), 32'h4);
      tick();
      dout = 8'h3C; m_done = 1'b1;
      tick();
      m_done = 1'b0; dout = 8'h00;
      chk("rd_done", 32'(done), 32'h4);
      chk("rd_rdata", 32'(rdata), 32'h3C);
      req = '0;
      tick(); tick();

      // 4. round robin: one request on 3 moves the pointer to 0, then all four held
      set_req(3, 1'b1, 8'h30, 8'h33);
      tick();
      wait_transfer();
      m_done = 1'b1; tick(); m_done = 1'b0;
      req = '0;
      tick(); tick();
      for (int r = 0; r < N; r++) set_req(r, r[0], AW'(8'h10 + r), DW'(8'h80 + r));
      for (int t = 0; t < 5; t++) begin
         tick();
         wait_transfer();
         order.push_back(oh_idx(grant));
         m_done = 1'b1; tick(); m_done = 1'b0;
         if (t == 4) req = '0;
      end
      chk("rr_count", 32'(order.size()), 32'd5);
      for (int t = 0; t < 5 && t < order.size(); t++)
         chk("rr_order", 32'(order[t]), 32'(exp_order[t]));
      tick(); tick();

      // 5. timeout: pointer sits at 1, master never answers
      set_req(1, 1'b0, 8'h55, 8'h00);
      tick();
      wait_transfer();
      busy_cycles = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (transfer === 1'b1) busy_cycles++;
         else break;
      end
      chk("to_busy_cycles", 32'(busy_cycles), 32'd16);
      chk("to_err", 32'(err), 32'h2);
      chk("to_no_done", 32'(done), 32'd0);
      req = '0;
      tick(); tick();

      // 6a. reset in the middle of a transaction
      set_req(2, 1'b1, 8'h77, 8'h11);
      tick();
      wait_transfer();
      tick();
      reset = 1'b1;
      tick();
      chk("abort_transfer", 32'(transfer), 32'd0);
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_pulses", 32'({done, err}), 32'd0);
      reset = 1'b0; req = '0;
      tick(); tick();

      // 6b. m_done lands on the timeout cycle
      set_req(0, 1'b0, 8'h99, 8'h00);
      tick();
      wait_transfer();
      repeat (15) tick();
      dout = 8'h5A; m_done = 1'b1;
      tick();
      m_done = 1'b0; dout = 8'h00;
      chk("col_done", 32'(done), 32'h1);
      chk("col_no_err", 32'(err), 32'd0);
      chk("col_rdata", 32'(rdata), 32'h5A);
      req = '0;
      repeat (4) tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
